// File: rtl/match_engine_pkg.sv
// Shared types and helpers for the lazy-match request/response engine.
// Default geometry macros are supplied here when the build does not define them.
`ifndef LAZY_LEN
`define LAZY_LEN 4
`endif
`ifndef NUM_MATCH_REQ_CH
`define NUM_MATCH_REQ_CH 2
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 2
`endif
`ifndef HISTORY_ADDR_WIDTH
`define HISTORY_ADDR_WIDTH 16
`endif

package match_engine_pkg;

    localparam int TAG_W = `LAZY_LEN_LOG2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } disp_state_t;

    // Lanes are statically striped across the request channels.
    function automatic int lane_chan(input int lane, input int num_ch);
        return lane % num_ch;
    endfunction

endpackage

// File: rtl/match_req_lane_pick.sv
// Per-channel picker: lowest-indexed pending lane mapped to channel CH,
// with its index and a one-hot mask used to retire it on fire.
module match_req_lane_pick
    import match_engine_pkg::*;
#(
    parameter int L        = `LAZY_LEN,
    parameter int C        = `NUM_MATCH_REQ_CH,
    parameter int CH       = 0,
    parameter int TAG_BITS = TAG_W
) (
    input  logic [L-1:0]        pending,
    output logic                valid,
    output logic [TAG_BITS-1:0] lane_idx,
    output logic [L-1:0]        clr_mask
);

    always_comb begin
        valid    = 1'b0;
        lane_idx = '0;
        clr_mask = '0;
        // Scan downward so the last hit is the lowest lane.
        for (int i = L - 1; i >= 0; i--) begin
            if (pending[i] && (lane_chan(i, C) == CH)) begin
                valid       = 1'b1;
                lane_idx    = TAG_BITS'(i);
                clr_mask    = '0;
                clr_mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/match_req_dispatch.sv
// Lazy-match request dispatcher: accepts a request group and issues it over C channels.
// Optional stall counter enabled by MATCH_REQ_DISPATCH_PERF_EN.
//
// state     | meaning
// IDLE      | ready for a new request group
// ISSUE     | pending lanes being issued on the match-request channels
// WAIT_RESP | all issued; waiting for the response group to be consumed
module match_req_dispatch
    import match_engine_pkg::*;
#(
    parameter int JOB_PE_IDX = 0,
    parameter int L          = `LAZY_LEN,
    parameter int C          = `NUM_MATCH_REQ_CH,
    parameter int TAG_BITS   = `LAZY_LEN_LOG2,
    parameter int AW         = `HISTORY_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  grp_valid,
    output logic                  grp_ready,
    input  logic [L-1:0]          grp_strb,
    input  logic [L*AW-1:0]       grp_addr,
    output logic                  req_group_fire,
    output logic [L-1:0]          req_group_strb,
    input  logic                  resp_group_fire,
    output logic [C-1:0]          req_valid,
    input  logic [C-1:0]          req_ready,
    output logic [C*TAG_BITS-1:0] req_tag,
    output logic [C*AW-1:0]       req_addr,
    output logic [31:0]           perf_stall_cycles
);

    wire [31:0] unused_job_pe_idx = JOB_PE_IDX;

    disp_state_t          state, state_nxt;
    logic [L-1:0]         pending, pending_nxt;
    logic [L*AW-1:0]      addr_reg;
    logic                 accept;
    logic [C-1:0]         pick_valid;
    logic [C*TAG_BITS-1:0] pick_lane;
    logic [L-1:0]         pick_clr [C];
    logic [L-1:0]         clr_mask;

    for (genvar c = 0; c < C; c++) begin : g_ch
        match_req_lane_pick #(
            .L        (L),
            .C        (C),
            .CH       (c),
            .TAG_BITS (TAG_BITS)
        ) u_pick (
            .pending  (pending),
            .valid    (pick_valid[c]),
            .lane_idx (pick_lane[c*TAG_BITS +: TAG_BITS]),
            .clr_mask (pick_clr[c])
        );
        assign req_tag[c*TAG_BITS +: TAG_BITS] = pick_lane[c*TAG_BITS +: TAG_BITS];
        assign req_addr[c*AW +: AW] = addr_reg[pick_lane[c*TAG_BITS +: TAG_BITS]*AW +: AW];
    end

    assign req_valid = (state == ISSUE) ? pick_valid : '0;

    always_comb begin
        clr_mask = '0;
        for (int c = 0; c < C; c++) begin
            if (req_valid[c] && req_ready[c]) clr_mask = clr_mask | pick_clr[c];
        end
    end

    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        grp_ready      = 1'b0;
        accept         = 1'b0;
        req_group_fire = 1'b0;
        req_group_strb = '0;
        case (state)
            IDLE: begin
                grp_ready = 1'b1;
                accept    = grp_valid;
            end
            ISSUE: begin
                pending_nxt = pending & ~clr_mask;
                if (pending_nxt == '0) state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                // Bypass: the response-group handshake frees the slot this cycle.
                grp_ready = resp_group_fire;
                if (resp_group_fire) begin
                    if (grp_valid) accept = 1'b1;
                    else state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            req_group_fire = 1'b1;
            req_group_strb = grp_strb;
            pending_nxt    = grp_strb;
            state_nxt      = (grp_strb != '0) ? ISSUE : WAIT_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            addr_reg <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (accept) addr_reg <= grp_addr;
        end
    end

`ifdef MATCH_REQ_DISPATCH_PERF_EN
    logic stall;
    assign stall = (state == ISSUE) && (|(req_valid & ~req_ready));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
        end else if (stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_match_req_dispatch.sv
// Self-checking bench for match_req_dispatch (L=4, C=2) against a queue-based reference model.
module tb_match_req_dispatch;

    localparam int L  = 4;
    localparam int C  = 2;
    localparam int TB = 2;
    localparam int AW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             grp_valid;
    logic             grp_ready;
    logic [L-1:0]     grp_strb;
    logic [L*AW-1:0]  grp_addr;
    logic             req_group_fire;
    logic [L-1:0]     req_group_strb;
    logic             resp_group_fire;
    logic [C-1:0]     req_valid;
    logic [C-1:0]     req_ready;
    logic [C*TB-1:0]  req_tag;
    logic [C*AW-1:0]  req_addr;
    logic [31:0]      perf_stall_cycles;

    match_req_dispatch #(
        .JOB_PE_IDX (0),
        .L          (L),
        .C          (C),
        .TAG_BITS   (TB),
        .AW         (AW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .grp_valid         (grp_valid),
        .grp_ready         (grp_ready),
        .grp_strb          (grp_strb),
        .grp_addr          (grp_addr),
        .req_group_fire    (req_group_fire),
        .req_group_strb    (req_group_strb),
        .resp_group_fire   (resp_group_fire),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_tag           (req_tag),
        .req_addr          (req_addr),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one FIFO of lane numbers per channel plus a group-outstanding flag.
    int          q [C][$];
    logic [7:0]  m_addr [L];
    bit          outstanding;
    int unsigned m_stall;

    bit              issuing;
    logic            e_ready;
    logic            e_accept;
    logic [C-1:0]    e_valid;
    logic [59:0]     exp_vec;
    logic [59:0]     obs_vec;

    function automatic void model_reset();
        for (int c = 0; c < C; c++) q[c].delete();
        for (int i = 0; i < L; i++) m_addr[i] = '0;
        outstanding = 1'b0;
        m_stall     = 0;
    endfunction

    function automatic void model_eval();
        logic [C*TB-1:0] e_tag;
        logic [C*AW-1:0] e_addr;
        logic [C*TB-1:0] tmask;
        logic [C*AW-1:0] amask;
        logic [31:0]     e_perf;
        issuing = 1'b0;
        for (int c = 0; c < C; c++) if (q[c].size() != 0) issuing = 1'b1;
        e_ready  = !outstanding ? 1'b1 : (issuing ? 1'b0 : resp_group_fire);
        e_accept = grp_valid && e_ready;
        e_tag = '0; e_addr = '0; tmask = '0; amask = '0;
        for (int c = 0; c < C; c++) begin
            e_valid[c] = (q[c].size() != 0);
            if (e_valid[c]) begin
                e_tag[c*TB +: TB]  = TB'(q[c][0]);
                e_addr[c*AW +: AW] = m_addr[q[c][0]];
                tmask[c*TB +: TB]  = '1;
                amask[c*AW +: AW]  = '1;
            end
        end
`ifdef MATCH_REQ_DISPATCH_PERF_EN
        e_perf = m_stall;
`else
        e_perf = 32'd0;
`endif
        exp_vec = {e_ready, e_accept, (e_accept ? grp_strb : 4'b0), e_valid, e_tag, e_addr, e_perf};
        obs_vec = {grp_ready, req_group_fire, req_group_strb, req_valid,
                   req_tag & tmask, req_addr & amask, perf_stall_cycles};
    endfunction

    function automatic void model_commit();
        if (issuing) begin
            if (|(e_valid & ~req_ready)) m_stall++;
            for (int c = 0; c < C; c++) if (e_valid[c] && req_ready[c]) void'(q[c].pop_front());
        end
        if (outstanding && !issuing && resp_group_fire && !e_accept) outstanding = 1'b0;
        if (e_accept) begin
            outstanding = 1'b1;
            for (int i = 0; i < L; i++) begin
                m_addr[i] = grp_addr[i*AW +: AW];
                if (grp_strb[i]) q[i % C].push_back(i);
            end
        end
    endfunction

    task automatic drive(input logic gv, input logic [3:0] strb, input logic [31:0] addr,
                         input logic resp, input logic [1:0] rdy);
        grp_valid       = gv;
        grp_strb        = strb;
        grp_addr        = addr;
        resp_group_fire = resp;
        req_ready       = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        model_eval();
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL reset_state got=%h want=%h", obs_vec, exp_vec);
        end
        n_cmp++;
        if ({grp_ready, req_valid, perf_stall_cycles} !== {1'b1, 2'b00, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b/%b/%0d want=1/00/0", grp_ready, req_valid, perf_stall_cycles);
        end
    endtask

    task automatic test_full_group();
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            drive(cyc == 0, 4'b1111, 32'h0D0C0B0A, cyc == 6, 2'b11);
            #1;
            model_eval();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL full_group c%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (cyc == 1) begin
                n_cmp++;
                if ({req_valid, req_tag, req_addr} !== {2'b11, 2'd1, 2'd0, 8'h0B, 8'h0A}) begin
                    n_bad++;
                    $display("FAIL full_group_first got=%b %h %h want=11 4 0b0a", req_valid, req_tag, req_addr);
                end
            end
            model_commit();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            drive(cyc == 0, 4'b0101, 32'h44332211, cyc == 7, (cyc >= 1 && cyc <= 3) ? 2'b00 : 2'b11);
            #1;
            model_eval();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL backpressure c%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            model_commit();
        end
        n_cmp++;
`ifdef MATCH_REQ_DISPATCH_PERF_EN
        if (perf_stall_cycles !== 32'd3) begin
            n_bad++;
            $display("FAIL perf_stall got=%0d want=3", perf_stall_cycles);
        end
`else
        if (perf_stall_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_stall got=%0d want=0", perf_stall_cycles);
        end
`endif
    endtask

    task automatic test_zero_strb();
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            drive(cyc == 0, 4'b0000, 32'hA5A5A5A5, cyc == 1, 2'b11);
            #1;
            model_eval();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL zero_strb c%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            model_commit();
        end
    endtask

    task automatic test_back_to_back();
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            drive(cyc == 0 || cyc == 3, (cyc == 0) ? 4'b0011 : 4'b1100,
                  (cyc == 0) ? 32'h00002221 : 32'h66550000, cyc == 3 || cyc == 6, 2'b11);
            #1;
            model_eval();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL back_to_back c%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (cyc == 3) begin
                n_cmp++;
                if ({grp_ready, req_group_fire} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL bypass_accept got=%b%b want=11", grp_ready, req_group_fire);
                end
            end
            model_commit();
        end
    endtask

    task automatic test_reset_mid_issue();
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            rst_n = (cyc != 2);
            drive(cyc == 0, 4'b0011, 32'h00007788, 1'b0, 2'b00);
            #1;
            model_eval();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL reset_mid_issue c%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (cyc == 3) begin
                n_cmp++;
                if ({req_valid, grp_ready} !== 3'b001) begin
                    n_bad++;
                    $display("FAIL reset_mid_issue_idle got=%b/%b want=00/1", req_valid, grp_ready);
                end
            end
            if (cyc == 2) model_reset();
            else model_commit();
        end
    endtask

    task automatic test_spurious_resp();
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            drive(cyc == 1, 4'b1011, 32'hB4B3B2B1, cyc == 0 || cyc == 2 || cyc == 3 || cyc == 7,
                  (cyc == 2) ? 2'b00 : 2'b11);
            #1;
            model_eval();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL spurious_resp c%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            model_commit();
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            drive($urandom_range(1, 0) == 1, 4'($urandom), $urandom,
                  $urandom_range(3, 0) == 0, 2'($urandom));
            #1;
            model_eval();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random c%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            model_commit();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 1'b0, 2'b00);
        model_reset();
        test_reset();
        test_full_group();
        test_backpressure();
        test_zero_strb();
        test_back_to_back();
        test_reset_mid_issue();
        test_spurious_resp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/match_req_dispatch.md
Name: match_req_dispatch

Overview:
- Initiator side of the lazy-match request/response protocol.
- Accepts one request group of up to L lazy-position requests from a job_pe and issues them over C match-request channels, each tagged with its lazy index.
- Pulses req_group_fire/req_group_strb toward the paired response synchronizer.
- Holds off the next group until that synchronizer reports the previous response group consumed.

Parameters:
JOB_PE_IDX, 0, instance index (perf/debug identification only)
L, `LAZY_LEN, requests per group
C, `NUM_MATCH_REQ_CH, number of match-request channels
TAG_BITS, `LAZY_LEN_LOG2, tag width (lazy index)
AW, `HISTORY_ADDR_WIDTH, per-request history address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
grp_valid  in  1  job_pe offers request group
grp_ready  out  1  group accepted when grp_valid&grp_ready
grp_strb  in  L  bit i=1: lane i carries a real request
grp_addr  in  L*AW  per-lane history address
req_group_fire  out  1  one-cycle pulse on group accept (to response sync)
req_group_strb  out  L  copy of grp_strb, valid with req_group_fire
resp_group_fire  in  1  response sync's resp_group_valid&resp_group_ready
req_valid  out  C  per-channel request valid
req_ready  in  C  per-channel request ready
req_tag  out  C*TAG_BITS  lazy index of the request on channel c
req_addr  out  C*AW  history address of the request on channel c
perf_stall_cycles  out  32  channel backpressure cycle count (see Optional Feature)

Behaviour:
- Clock clk; reset rst_n, synchronous, active-low.
- Reset: state=IDLE, pending=0, all addr/tag registers=0, grp_ready=1, req_valid=0, req_group_fire=0, req_group_strb=0, perf_stall_cycles=0.
- State IDLE: grp_ready=1.
  - On accept: register grp_strb into pending and grp_addr into addr_reg.
  - Same cycle (combinational), drive req_group_fire=1 and req_group_strb=grp_strb.
  - Next state: ISSUE if grp_strb!=0, else WAIT_RESP.
- State ISSUE:
  - Lane i is statically mapped to channel i%C.
  - req_valid[c] = 1 iff some pending lane maps to c.
  - req_tag[c]/req_addr[c] come from the lowest-indexed such pending lane.
  - On req_valid[c]&req_ready[c], clear that lane's pending bit. Multiple channels may fire in the same cycle.
  - When every pending bit is cleared (including by fires this cycle), go to WAIT_RESP the next cycle.
- req_valid/tag/addr stability: once req_valid[c] is asserted, the channel holds valid, tag and addr stable until it fires. This is guaranteed because lowest-pending selection changes only on that channel's own fire.
- State WAIT_RESP: req_valid=0.
  - grp_ready=resp_group_fire (bypass).
  - resp_group_fire without grp_valid: go to IDLE.
  - resp_group_fire with grp_valid: accept the new group immediately, as in IDLE.
- resp_group_fire is ignored in IDLE and ISSUE; the response group cannot complete before all requests are issued.
- Channels with c>=L never assert req_valid.
- grp_strb=0 group: fire pulse still issued with strb=0; the response sync completes it immediately; WAIT_RESP is then exited on resp_group_fire.
- Latency: group accept to first req_valid = 1 cycle. Minimum group period = ceil(max lanes per channel) issue cycles + response wait.
- Reset mid-ISSUE: pending is dropped, no further req_valid. Partially issued requests are the system's responsibility because response-side modules reset together.

Optional Feature:
- Macro MATCH_REQ_DISPATCH_PERF_EN.
- Defined: 32-bit saturating perf_stall_cycles increments each cycle in ISSUE where any req_valid[c]&~req_ready[c]; cleared by reset only.
- Undefined: perf_stall_cycles tied to 0 and no counter logic is generated; all other behaviour is identical.

Decomposition:
- Shared package match_engine_pkg: state enum (IDLE, ISSUE, WAIT_RESP), lane-to-channel mapping function (i%C), tag width constant.
- One sub-module, match_req_lane_pick: per channel, selects the lowest pending lane for that channel and outputs valid, lane index and a one-hot clear mask; instantiated C times.

Test Plan:
- L=4,C=2, strb=1111, addrs 10/11/12/13, req_ready=11 always: cycle1 ch0 tag0 addr10, ch1 tag1 addr11; cycle2 tags 2/3. WAIT_RESP; grp_ready=0 until resp_group_fire.
- strb=0101, ch0 req_ready low 3 cycles: ch0 holds tag0 stable 3 cycles, then tag2; ch1 never valid; with PERF_EN, perf_stall_cycles=3.
- strb=0000: req_group_fire pulse with strb=0; no req_valid; resp_group_fire next cycle returns to IDLE.
- WAIT_RESP with grp_valid=1 and resp_group_fire=1 in the same cycle: group accepted that cycle, req_group_fire=1, ISSUE next cycle.
- rst_n low during ISSUE with 2 lanes pending: next cycle req_valid=0, grp_ready=1, state IDLE.
- resp_group_fire asserted spuriously in ISSUE: ignored, issuing continues unchanged.
